// File: rtl/bp_me_router_pkg.sv
// Shared definitions for the memory-command router: target-id sizing,
// the decode-error id and the address window match.
package bp_me_router_pkg;

    // Widest supported configuration; ids also need one code for decode errors.
    localparam int unsigned max_targets_lp   = 8;
    localparam int unsigned max_id_width_lp  = $clog2(max_targets_lp + 1);
    localparam int unsigned match_width_lp   = 64;

    // Bits needed for a target id plus the decode-error code.
    function automatic int unsigned tgt_id_width(input int unsigned num_targets);
        return $clog2(num_targets + 1);
    endfunction

    // The decode-error id sits one past the last real target.
    function automatic int unsigned decerr_id(input int unsigned num_targets);
        return num_targets;
    endfunction

    // Inclusive base, exclusive limit, unsigned.
    function automatic logic addr_in_window(input logic [match_width_lp-1:0] addr,
                                            input logic [match_width_lp-1:0] base,
                                            input logic [match_width_lp-1:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with occupancy count. Holds the target id of
// every issued command so responses can be returned in command order.
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 2,
    parameter int unsigned els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [cnt_width_lp-1:0] count_q;
    logic                    push, pop;

    // Explicit wrap keeps a single-entry FIFO correct.
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count_q != cnt_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // Pointers and occupancy; simultaneous push and pop leaves the count as is.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= next_ptr(wptr_q);
            if (pop)  rptr_q <= next_ptr(rptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_mem_cmd_router.sv
// N-way memory-command router: decodes the command address against per-target
// windows, issues to one target, tracks issue order and returns responses in
// command order. Optional feature macro: BP_ME_ROUTER_DECERR_EN (unmapped
// addresses get a local error response instead of going to the last target).
module bp_me_mem_cmd_router
    import bp_me_router_pkg::*;
#(
    parameter int unsigned num_targets_p     = 2,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned paddr_width_p     = 39,
    parameter int unsigned cmd_width_p       = 128,
    parameter int unsigned resp_width_p      = 128,
    parameter int unsigned addr_offset_p     = 0,
    parameter logic [num_targets_p*paddr_width_p-1:0] target_base_p  =
        {39'h0_4000_0000, 39'h0_0000_0000},
    parameter logic [num_targets_p*paddr_width_p-1:0] target_limit_p =
        {39'h0_8000_0000, 39'h0_4000_0000}
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [cmd_width_p-1:0]                 mem_cmd_i,
    input  logic                                   mem_cmd_v_i,
    output logic                                   mem_cmd_yumi_o,
    output logic [resp_width_p-1:0]                mem_resp_o,
    output logic                                   mem_resp_v_o,
    input  logic                                   mem_resp_ready_i,
    output logic                                   mem_resp_err_o,
    output logic [cmd_width_p-1:0]                 tgt_cmd_o,
    output logic [num_targets_p-1:0]               tgt_cmd_v_o,
    input  logic [num_targets_p-1:0]               tgt_cmd_yumi_i,
    input  logic [num_targets_p*resp_width_p-1:0]  tgt_resp_i,
    input  logic [num_targets_p-1:0]               tgt_resp_v_i,
    output logic [num_targets_p-1:0]               tgt_resp_ready_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

    localparam int unsigned id_width_lp = tgt_id_width(num_targets_p);
    localparam logic [id_width_lp-1:0] decerr_id_lp = id_width_lp'(decerr_id(num_targets_p));

    logic [paddr_width_p-1:0] addr;
    logic [num_targets_p-1:0] match;
    logic                     mapped;
    logic [id_width_lp-1:0]   sel_id;
    logic [id_width_lp-1:0]   push_id;
    logic [id_width_lp-1:0]   head_id;
    logic                     cmd_routable;
    logic                     decerr_issue;
    logic                     can_issue;
    logic                     fifo_ready;
    logic                     fifo_v;
    logic                     push;
    logic                     pop;

    assign addr      = mem_cmd_i[addr_offset_p +: paddr_width_p];
    assign tgt_cmd_o = mem_cmd_i;
    // Nothing issues while full, even if the head pops this cycle.
    assign can_issue = mem_cmd_v_i & fifo_ready & ~reset_i;

    // Per-target window match on the command address.
    always_comb begin
        match = '0;
        for (int t = 0; t < num_targets_p; t++) begin
            match[t] = addr_in_window(
                match_width_lp'(addr),
                match_width_lp'(target_base_p[t*paddr_width_p +: paddr_width_p]),
                match_width_lp'(target_limit_p[t*paddr_width_p +: paddr_width_p]));
        end
    end

    // Lowest matching index wins; an unmapped address falls back to the last target.
    always_comb begin
        mapped = |match;
        sel_id = id_width_lp'(num_targets_p - 1);
        for (int t = num_targets_p - 1; t >= 0; t--) begin
            if (match[t]) sel_id = id_width_lp'(t);
        end
    end

`ifdef BP_ME_ROUTER_DECERR_EN
    assign cmd_routable = mapped;
    assign decerr_issue = can_issue & ~mapped;
    assign push_id      = mapped ? sel_id : decerr_id_lp;
`else
    assign cmd_routable = 1'b1;
    assign decerr_issue = 1'b0;
    assign push_id      = sel_id;
`endif

    // One-hot command valid towards the decoded target.
    always_comb begin
        tgt_cmd_v_o = '0;
        for (int t = 0; t < num_targets_p; t++) begin
            tgt_cmd_v_o[t] = can_issue & cmd_routable & (sel_id == id_width_lp'(t));
        end
    end

    assign push           = (|(tgt_cmd_yumi_i & tgt_cmd_v_o)) | decerr_issue;
    assign mem_cmd_yumi_o = push;

    // Forward only the head target's response; other targets stall.
    always_comb begin
        mem_resp_v_o     = 1'b0;
        mem_resp_o       = '0;
        mem_resp_err_o   = 1'b0;
        tgt_resp_ready_o = '0;
        if (fifo_v) begin
            for (int t = 0; t < num_targets_p; t++) begin
                if (head_id == id_width_lp'(t)) begin
                    mem_resp_v_o        = tgt_resp_v_i[t];
                    mem_resp_o          = tgt_resp_i[t*resp_width_p +: resp_width_p];
                    tgt_resp_ready_o[t] = mem_resp_ready_i;
                end
            end
`ifdef BP_ME_ROUTER_DECERR_EN
            if (head_id == decerr_id_lp) begin
                mem_resp_v_o   = 1'b1;
                mem_resp_err_o = 1'b1;
            end
`endif
        end
    end

    assign pop = mem_resp_v_o & mem_resp_ready_i;

    bsg_fifo_1r1w_small #(
        .width_p (id_width_lp),
        .els_p   (max_outstanding_p)
    ) order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (push),
        .data_i  (push_id),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (head_id),
        .yumi_i  (pop),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_bp_me_mem_cmd_router.sv
// Self-checking bench for bp_me_mem_cmd_router: directed scenarios followed by
// randomized traffic, all checked against an in-order queue model.
module tb_bp_me_mem_cmd_router;

    localparam int NT   = 2;
    localparam int MAXO = 4;
    localparam int CW   = 128;
    localparam int RW   = 128;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [CW-1:0]        mem_cmd;
    logic                 mem_cmd_v;
    logic                 mem_cmd_yumi;
    logic [RW-1:0]        mem_resp;
    logic                 mem_resp_v;
    logic                 mem_resp_ready;
    logic                 mem_resp_err;
    logic [CW-1:0]        tgt_cmd;
    logic [NT-1:0]        tgt_cmd_v;
    logic [NT-1:0]        tgt_cmd_yumi;
    logic [NT*RW-1:0]     tgt_resp;
    logic [NT-1:0]        tgt_resp_v;
    logic [NT-1:0]        tgt_resp_ready;
    logic [2:0]           outstanding;

    int vectors     = 0;
    int miscompares = 0;
    int ord_q[$];
    logic last_yumi = 1'b0;

    bp_me_mem_cmd_router #(
        .num_targets_p     (NT),
        .max_outstanding_p (MAXO),
        .paddr_width_p     (39),
        .cmd_width_p       (CW),
        .resp_width_p      (RW),
        .addr_offset_p     (0),
        .target_base_p     ({39'h0_4000_0000, 39'h0_0000_0000}),
        .target_limit_p    ({39'h0_8000_0000, 39'h0_4000_0000})
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .mem_cmd_i        (mem_cmd),
        .mem_cmd_v_i      (mem_cmd_v),
        .mem_cmd_yumi_o   (mem_cmd_yumi),
        .mem_resp_o       (mem_resp),
        .mem_resp_v_o     (mem_resp_v),
        .mem_resp_ready_i (mem_resp_ready),
        .mem_resp_err_o   (mem_resp_err),
        .tgt_cmd_o        (tgt_cmd),
        .tgt_cmd_v_o      (tgt_cmd_v),
        .tgt_cmd_yumi_i   (tgt_cmd_yumi),
        .tgt_resp_i       (tgt_resp),
        .tgt_resp_v_i     (tgt_resp_v),
        .tgt_resp_ready_o (tgt_resp_ready),
        .outstanding_o    (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: window 0 is [0,1G), window 1 is [1G,2G).
    function automatic int exp_target(input logic [38:0] a);
        if (a < 39'h0_4000_0000) return 0;
        if (a < 39'h0_8000_0000) return 1;
`ifdef BP_ME_ROUTER_DECERR_EN
        return NT;
`else
        return NT - 1;
`endif
    endfunction

    task automatic set_cmd(input logic [38:0] a);
        mem_cmd = {$urandom, $urandom, $urandom, $urandom};
        mem_cmd[38:0] = a;
    endtask

    // Check all outputs against the model mid-cycle, then advance one clock.
    task automatic cycle();
        int id;
        int hd;
        bit full;
        logic [NT-1:0] e_v;
        logic [NT-1:0] e_rr;
        logic e_yumi, e_rv, e_err;
        logic [RW-1:0] e_rd;
        #2;
        full   = ord_q.size() >= MAXO;
        id     = exp_target(mem_cmd[38:0]);
        e_v    = '0;
        if (mem_cmd_v && !full && id < NT) e_v = NT'(1 << id);
        e_yumi = (|(tgt_cmd_yumi & e_v)) || (mem_cmd_v && !full && id == NT);
        e_rv = 1'b0; e_err = 1'b0; e_rd = '0; e_rr = '0;
        if (ord_q.size() > 0) begin
            hd = ord_q[0];
            if (hd == NT) begin
                e_rv  = 1'b1;
                e_err = 1'b1;
            end else begin
                e_rv = tgt_resp_v[hd];
                e_rd = tgt_resp[hd*RW +: RW];
                if (mem_resp_ready) e_rr = NT'(1 << hd);
            end
        end
        if (!reset) begin
            check("outstanding", 128'(outstanding), 128'(ord_q.size()));
            check("tgt_cmd_v", 128'(tgt_cmd_v), 128'(e_v));
            check("cmd_yumi", 128'(mem_cmd_yumi), 128'(e_yumi));
            check("resp_v", 128'(mem_resp_v), 128'(e_rv));
            check("resp_err", 128'(mem_resp_err), 128'(e_err));
            check("tgt_resp_ready", 128'(tgt_resp_ready), 128'(e_rr));
            if (e_rv) check("resp_data", mem_resp, e_rd);
            if (e_v != '0) check("tgt_cmd", tgt_cmd, mem_cmd);
        end
        @(posedge clk);
        #1;
        last_yumi = e_yumi;
        if (reset) begin
            ord_q.delete();
        end else begin
            if (e_rv && mem_resp_ready) void'(ord_q.pop_front());
            if (e_yumi) ord_q.push_back(id);
        end
    endtask

    initial begin
        logic [38:0] a;
        int r;
        reset          = 1'b1;
        mem_cmd        = '0;
        mem_cmd_v      = 1'b0;
        mem_resp_ready = 1'b0;
        tgt_cmd_yumi   = '0;
        tgt_resp       = '0;
        tgt_resp_v     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_outstanding", 128'(outstanding), 128'd0);
        check("reset_tgt_cmd_v", 128'(tgt_cmd_v), 128'd0);
        check("reset_resp_v", 128'(mem_resp_v), 128'd0);
        cycle();

        // Basic decode and in-order return.
        tgt_cmd_yumi = 2'b11;
        mem_cmd_v    = 1'b1;
        set_cmd(39'h80);
        #1 check("decode_t0", 128'(tgt_cmd_v), 128'b01);
        cycle();
        set_cmd(39'h0_4000_0010);
        #1 check("decode_t1", 128'(tgt_cmd_v), 128'b10);
        cycle();
        mem_cmd_v      = 1'b0;
        tgt_resp       = {128'hB1B1, 128'hA0A0};
        tgt_resp_v     = 2'b11;
        mem_resp_ready = 1'b1;
        #1 check("order_first", mem_resp, 128'hA0A0);
        cycle();
        #1 check("order_second", mem_resp, 128'hB1B1);
        cycle();

        // Non-head target responding first must stall.
        mem_cmd_v  = 1'b1;
        tgt_resp_v = 2'b00;
        set_cmd(39'h100);
        cycle();
        set_cmd(39'h0_4000_0200);
        cycle();
        mem_cmd_v  = 1'b0;
        tgt_resp_v = 2'b10;
        #1 check("stall_resp_v", 128'(mem_resp_v), 128'd0);
        check("stall_ready1", 128'(tgt_resp_ready[1]), 128'd0);
        cycle();
        cycle();
        tgt_resp_v = 2'b11;
        cycle();
        cycle();

        // Fill to capacity, then pop and push in the same cycle.
        tgt_resp_v = 2'b00;
        mem_cmd_v  = 1'b1;
        set_cmd(39'h0_4000_0100);
        repeat (4) cycle();
        #1 check("full_count", 128'(outstanding), 128'd4);
        check("full_no_issue", 128'(tgt_cmd_v), 128'd0);
        check("full_no_yumi", 128'(mem_cmd_yumi), 128'd0);
        cycle();
        tgt_resp_v = 2'b10;
        #1 check("full_pop_no_issue", 128'(tgt_cmd_v), 128'd0);
        check("full_pop_resp_v", 128'(mem_resp_v), 128'd1);
        cycle();
        tgt_resp_v = 2'b00;
        #1 check("after_pop_count", 128'(outstanding), 128'd3);
        check("after_pop_issue", 128'(tgt_cmd_v), 128'b10);
        cycle();
        #1 check("refill_count", 128'(outstanding), 128'd4);
        mem_cmd_v  = 1'b0;
        tgt_resp_v = 2'b10;
        repeat (4) cycle();
        #1 check("drained", 128'(outstanding), 128'd0);

        // Unmapped address.
        tgt_resp_v = 2'b00;
        mem_cmd_v  = 1'b1;
        set_cmd(39'h0_F000_0000);
`ifdef BP_ME_ROUTER_DECERR_EN
        #1 check("decerr_yumi", 128'(mem_cmd_yumi), 128'd1);
        check("decerr_no_tgt", 128'(tgt_cmd_v), 128'd0);
        cycle();
        mem_cmd_v = 1'b0;
        #1 check("decerr_resp_v", 128'(mem_resp_v), 128'd1);
        check("decerr_err", 128'(mem_resp_err), 128'd1);
        cycle();
`else
        #1 check("unmapped_to_last", 128'(tgt_cmd_v), 128'b10);
        cycle();
        mem_cmd_v  = 1'b0;
        tgt_resp_v = 2'b10;
        cycle();
`endif

        // Reset with commands in flight.
        tgt_resp_v = 2'b00;
        mem_cmd_v  = 1'b1;
        set_cmd(39'h40);
        repeat (3) cycle();
        #1 check("pre_reset_count", 128'(outstanding), 128'd3);
        mem_cmd_v = 1'b0;
        reset     = 1'b1;
        cycle();
        reset = 1'b0;
        #1 check("post_reset_count", 128'(outstanding), 128'd0);
        check("post_reset_tgt_v", 128'(tgt_cmd_v), 128'd0);
        check("post_reset_resp_v", 128'(mem_resp_v), 128'd0);
        check("post_reset_ready", 128'(tgt_resp_ready), 128'd0);
        cycle();

        // Randomized traffic; the command is held stable until consumed.
        last_yumi = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!mem_cmd_v || last_yumi) begin
                mem_cmd_v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 2);
                if (r == 0)      a = 39'($urandom_range(0, 32'h3fff_ffff));
                else if (r == 1) a = 39'h0_4000_0000 + 39'($urandom_range(0, 32'h3fff_ffff));
                else             a = {7'($urandom), 32'($urandom)} | 39'h0_8000_0000;
                set_cmd(a);
            end
            tgt_cmd_yumi   = NT'($urandom);
            tgt_resp_v     = NT'($urandom);
            mem_resp_ready = 1'($urandom);
            tgt_resp       = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
            reset          = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
